// File: rtl/trigger_run_controller_pkg.sv
// Shared encodings for the trigger run controller.
// Opcodes, states and selector trigger-type codes.
package trigger_run_controller_pkg;

  localparam int HARDWARE_TRG = 0;
  localparam int EXTERNAL_TRG = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CONFIG = 2'b01,
    ST_RUN    = 2'b10,
    ST_DRAIN  = 2'b11
  } run_state_e;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_CONFIG = 2'b01,
    OP_START  = 2'b10,
    OP_STOP   = 2'b11
  } cmd_op_e;

endpackage

// File: rtl/trigger_deadtime_gate.sv
// External trigger edge detect with dead-time gating.
// Counts edges rejected while the dead-time counter is busy.
module trigger_deadtime_gate #(
  parameter int DEADTIME_WIDTH = 16,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic                      clr,
  input  logic                      ext_in,
  input  logic [DEADTIME_WIDTH-1:0] deadtime,
  output logic                      pulse,
  output logic [COUNT_WIDTH-1:0]    drop_count
);

  logic                      ext_q;
  logic                      edge_w;
  logic                      pulse_q, pulse_d;
  logic [DEADTIME_WIDTH-1:0] dt_cnt_q, dt_cnt_d;
  logic [COUNT_WIDTH-1:0]    drop_q, drop_d;

  assign edge_w = ext_in & ~ext_q;

  always_comb begin
    dt_cnt_d = dt_cnt_q;
    pulse_d  = 1'b0;
    drop_d   = drop_q;
    if (!run) begin
      dt_cnt_d = '0;
    end else if (edge_w && dt_cnt_q == '0) begin
      pulse_d  = 1'b1;
      dt_cnt_d = deadtime;
    end else begin
      if (dt_cnt_q != '0) dt_cnt_d = dt_cnt_q - 1'b1;
      // edge here means the counter was busy
      if (edge_w && ~&drop_q) drop_d = drop_q + 1'b1;
    end
    if (clr) drop_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_q    <= 1'b0;
      pulse_q  <= 1'b0;
      dt_cnt_q <= '0;
      drop_q   <= '0;
    end else begin
      ext_q    <= ext_in;
      pulse_q  <= pulse_d;
      dt_cnt_q <= dt_cnt_d;
      drop_q   <= drop_d;
    end
  end

  assign pulse      = pulse_q;
  assign drop_count = drop_q;

endmodule

// File: rtl/trigger_run_controller.sv
// Run-control sequencer in front of trigger_selector.
// Optional run-length timer: define RUN_TIMER_EN.
module trigger_run_controller
  import trigger_run_controller_pkg::*;
#(
  parameter int TRIGGER_TYPE_WIDTH = 2,
  parameter int CONFIG_HOLD_CYCLES = 4,
  parameter int DRAIN_CYCLES       = 2,
  parameter int DEADTIME_WIDTH     = 16,
  parameter int COUNT_WIDTH        = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          CMD_VALID,
  output logic                          CMD_READY,
  input  logic [1:0]                    CMD_OPCODE,
  input  logic [TRIGGER_TYPE_WIDTH-1:0] CMD_TRIGGER_TYPE,
  input  logic [DEADTIME_WIDTH-1:0]     CMD_DEADTIME,
  output logic                          CMD_ERROR,
  input  logic                          EXT_TRIGGER_IN,
  input  logic                          SEL_TVALID,
`ifdef RUN_TIMER_EN
  input  logic [COUNT_WIDTH-1:0]        CMD_RUN_LENGTH,
  output logic                          RUN_TIMEOUT,
`endif
  output logic                          SET_CONFIG,
  output logic                          STOP,
  output logic [TRIGGER_TYPE_WIDTH-1:0] TRIGGER_TYPE,
  output logic                          EXTERNAL_TRIGGER,
  output logic                          RUN_ACTIVE,
  output logic [1:0]                    STATE,
  output logic [COUNT_WIDTH-1:0]        TRIGGER_COUNT,
  output logic [COUNT_WIDTH-1:0]        DROP_COUNT
);

  localparam int PH_MAX = (CONFIG_HOLD_CYCLES > DRAIN_CYCLES) ?
                          CONFIG_HOLD_CYCLES : DRAIN_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  run_state_e                    state_q, state_d;
  cmd_op_e                       op;
  logic                          accept;
  logic                          clr;
  logic                          in_run;
  logic                          timeout_hit;
  logic [PH_W-1:0]               ph_q, ph_d;
  logic                          cfg_q, cfg_d;
  logic [TRIGGER_TYPE_WIDTH-1:0] type_q, type_d;
  logic [DEADTIME_WIDTH-1:0]     dt_q, dt_d;
  logic                          ready_q, ready_d;
  logic                          err_q, err_d;
  logic                          setcfg_q, setcfg_d;
  logic                          stop_q, stop_d;
  logic                          active_q, active_d;
  logic                          tv_q;
  logic [COUNT_WIDTH-1:0]        trig_q, trig_d;

  assign op     = cmd_op_e'(CMD_OPCODE);
  assign accept = CMD_VALID & ready_q;
  assign in_run = (state_q == ST_RUN);

`ifdef RUN_TIMER_EN
  logic [COUNT_WIDTH-1:0] len_q, len_d;
  logic [COUNT_WIDTH-1:0] timer_q, timer_d;
  logic                   tmo_q;

  assign timeout_hit = in_run && len_q != '0 &&
                       timer_q == len_q - 1'b1;

  always_comb begin
    len_d   = len_q;
    timer_d = timer_q;
    if (state_q == ST_IDLE && accept && op == OP_CONFIG)
      len_d = CMD_RUN_LENGTH;
    if (clr)         timer_d = '0;
    else if (in_run) timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      len_q   <= '0;
      timer_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      len_q   <= len_d;
      timer_q <= timer_d;
      tmo_q   <= timeout_hit;
    end
  end

  assign RUN_TIMEOUT = tmo_q;
`else
  assign timeout_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      cfg_q   <= 1'b0;
      type_q  <= TRIGGER_TYPE_WIDTH'(HARDWARE_TRG);
      dt_q    <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cfg_q   <= cfg_d;
      type_q  <= type_d;
      dt_q    <= dt_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cfg_d   = cfg_q;
    type_d  = type_q;
    dt_d    = dt_q;
    err_d   = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (op)
            OP_CONFIG: begin
              state_d = ST_CONFIG;
              ph_d    = PH_W'(CONFIG_HOLD_CYCLES - 1);
              cfg_d   = 1'b1;
              type_d  = CMD_TRIGGER_TYPE;
              dt_d    = CMD_DEADTIME;
            end
            OP_START: begin
              if (cfg_q) begin
                state_d = ST_RUN;
                clr     = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_CONFIG: begin
        if (ph_q == '0) state_d = ST_IDLE;
        else            ph_d    = ph_q - 1'b1;
      end
      ST_RUN: begin
        if ((accept && op == OP_STOP) || timeout_hit) begin
          state_d = ST_DRAIN;
          ph_d    = PH_W'(DRAIN_CYCLES - 1);
        end else if (accept && op != OP_NOP) begin
          err_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (ph_q == '0) state_d = ST_IDLE;
        else            ph_d    = ph_q - 1'b1;
      end
    endcase
  end

  // registered outputs decoded from the next state
  always_comb begin
    ready_d  = (state_d == ST_IDLE) || (state_d == ST_RUN);
    setcfg_d = (state_d == ST_CONFIG);
    stop_d   = (state_d != ST_RUN);
    active_d = (state_d == ST_RUN);
    trig_d   = trig_q;
    if (clr) begin
      trig_d = '0;
    end else if ((in_run || state_q == ST_DRAIN) &&
                 SEL_TVALID && !tv_q && ~&trig_q) begin
      trig_d = trig_q + 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      setcfg_q <= 1'b0;
      stop_q   <= 1'b1;
      active_q <= 1'b0;
      tv_q     <= 1'b0;
      trig_q   <= '0;
    end else begin
      ready_q  <= ready_d;
      err_q    <= err_d;
      setcfg_q <= setcfg_d;
      stop_q   <= stop_d;
      active_q <= active_d;
      tv_q     <= SEL_TVALID;
      trig_q   <= trig_d;
    end
  end

  trigger_deadtime_gate #(
    .DEADTIME_WIDTH (DEADTIME_WIDTH),
    .COUNT_WIDTH    (COUNT_WIDTH)
  ) u_gate (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .run        (in_run),
    .clr        (clr),
    .ext_in     (EXT_TRIGGER_IN),
    .deadtime   (dt_q),
    .pulse      (EXTERNAL_TRIGGER),
    .drop_count (DROP_COUNT)
  );

  assign CMD_READY     = ready_q;
  assign CMD_ERROR     = err_q;
  assign SET_CONFIG    = setcfg_q;
  assign STOP          = stop_q;
  assign TRIGGER_TYPE  = type_q;
  assign RUN_ACTIVE    = active_q;
  assign STATE         = state_q;
  assign TRIGGER_COUNT = trig_q;

endmodule

// File: doc/trigger_run_controller.md
Name: trigger_run_controller

Overview:
Run-control sequencer in front of trigger_selector. Accepts software commands (CONFIG/START/STOP) over a valid/ready strobe interface and drives the selector's SET_CONFIG, STOP and TRIGGER_TYPE with the required timing. It also gates the external trigger with a programmable dead time and counts accepted and dropped triggers per run.

Parameters:
TRIGGER_TYPE_WIDTH, 2, width of trigger-type code; must match selector.
CONFIG_HOLD_CYCLES, 4, cycles SET_CONFIG stays high per CONFIG command; minimum 1.
DRAIN_CYCLES, 2, cycles STOP is held after a stop before IDLE; equals the selector tvalid pipeline depth.
DEADTIME_WIDTH, 16, width of the dead-time counter.
COUNT_WIDTH, 32, width of the trigger and drop counters.

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous reset, active-low
CMD_VALID  in  1  command strobe
CMD_READY  out  1  command accepted when CMD_VALID&CMD_READY
CMD_OPCODE  in  2  00 NOP, 01 CONFIG, 10 START, 11 STOP
CMD_TRIGGER_TYPE  in  TRIGGER_TYPE_WIDTH  type latched on CONFIG
CMD_DEADTIME  in  DEADTIME_WIDTH  dead time in cycles, latched on CONFIG
CMD_ERROR  out  1  1-cycle pulse on illegal command
EXT_TRIGGER_IN  in  1  external trigger, synchronous to ACLK
SEL_TVALID  in  1  selector M_AXIS_TVALID, used for counting
SET_CONFIG  out  1  to selector
STOP  out  1  to selector
TRIGGER_TYPE  out  TRIGGER_TYPE_WIDTH  to selector
EXTERNAL_TRIGGER  out  1  gated trigger to selector
RUN_ACTIVE  out  1  high in RUN
STATE  out  2  00 IDLE, 01 CONFIG, 10 RUN, 11 DRAIN
TRIGGER_COUNT  out  COUNT_WIDTH  SEL_TVALID rising edges this run
DROP_COUNT  out  COUNT_WIDTH  external edges rejected by dead time

Behaviour:
- Reset (ARESETN=0 at a clock edge): STATE=IDLE, STOP=1, SET_CONFIG=0, TRIGGER_TYPE=HARDWARE_TRG, EXTERNAL_TRIGGER=0, RUN_ACTIVE=0, CMD_READY=0, CMD_ERROR=0, counters=0, configured flag=0, dead-time counter=0. Reset mid-run aborts immediately; no drain.
- All outputs are registered. CMD_READY=1 in IDLE and RUN, starting the first cycle after reset release. It is 0 in CONFIG and DRAIN.
- IDLE, CONFIG: latch type and dead time, set configured flag, enter CONFIG.
- CONFIG state: SET_CONFIG=1 and STOP=1 for exactly CONFIG_HOLD_CYCLES cycles, then return to IDLE. TRIGGER_TYPE updates in the same cycle SET_CONFIG first rises.
- IDLE, START: if configured, enter RUN next cycle with STOP=0 and RUN_ACTIVE=1, and clear both counters. If not configured, raise CMD_ERROR and stay in IDLE.
- IDLE, STOP or NOP: accepted, no effect.
- RUN, STOP: enter DRAIN. STOP=1 from the next cycle. Hold DRAIN for DRAIN_CYCLES cycles, then go to IDLE. Counters are frozen in IDLE.
- RUN, CONFIG or START: CMD_ERROR pulse; state and configuration unchanged.
- Simultaneous events have no priority rules: only one command is accepted per cycle.
- Dead-time gate, active only in RUN:
  - A rising edge of EXT_TRIGGER_IN when the dead-time counter is 0 gives EXTERNAL_TRIGGER=1 for one cycle, one cycle after the edge. The counter loads the latched dead time.
  - The counter decrements by 1 per cycle down to 0.
  - A rising edge while the counter is nonzero is dropped and DROP_COUNT increments.
  - Dead time 0: every edge passes.
  - An edge in any other state is ignored and not counted.
  - Leaving RUN clears the counter.
- TRIGGER_COUNT: increments on each SEL_TVALID 0->1 transition in RUN or DRAIN.
- Both counters saturate at all-ones and never wrap.

Optional Feature:
RUN_TIMER_EN.
- With it defined:
  - Adds input CMD_RUN_LENGTH (COUNT_WIDTH), latched on CONFIG, and output RUN_TIMEOUT (1-cycle pulse).
  - In RUN a cycle counter starts at 0 on START. When it reaches CMD_RUN_LENGTH-1, the block enters DRAIN exactly as for a STOP command and pulses RUN_TIMEOUT.
  - Length 0 means unlimited.
  - A STOP command in the same cycle as the timeout takes the same path, with a single DRAIN.
- Without it: neither port exists; runs end only on a STOP command or reset.

Decomposition:
- HARDWARE_TRG/EXTERNAL_TRG come from the existing shared selector config header.
- New header run_ctrl_config.vh holds the opcode and STATE encodings, and the default widths.
- One sub-module: trigger_deadtime_gate, containing edge detect, dead-time counter, gated pulse and DROP_COUNT.

Test Plan:
- Reset release, then CONFIG (type=EXTERNAL_TRG, deadtime=10) -> SET_CONFIG high for 4 cycles, TRIGGER_TYPE=EXTERNAL_TRG, STOP=1 throughout, return to IDLE.
- START with no prior CONFIG after reset -> CMD_ERROR pulse, STATE stays IDLE.
- RUN with deadtime=10, EXT edges at t=0,5,12 -> EXTERNAL_TRIGGER at t=1 and t=13; DROP_COUNT=1.
- RUN, then STOP -> STOP=1 the next cycle, STATE=DRAIN for 2 cycles, then IDLE. SEL_TVALID edge during DRAIN counts, so TRIGGER_COUNT=+1.
- CONFIG issued in RUN -> CMD_ERROR pulse, SET_CONFIG stays 0, TRIGGER_TYPE unchanged. ARESETN=0 mid-RUN -> STOP=1 and all counters=0 next cycle.
- RUN_TIMER_EN with run length=100 -> RUN_TIMEOUT pulse on cycle 100 of RUN, then DRAIN and IDLE. Run length=0 -> no timeout after 10000 cycles.
